// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } btn_state_e;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debounce FSM, press/release pulses and auto-repeat.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pressed,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_next_c
);

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RP_W   = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam bit          DB_ONE = (DEBOUNCE_CYCLES == 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_FIRST   = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_PERIOD  = RP_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;

    btn_state_e      state_q, state_n;
    logic [DB_W-1:0] db_q, db_n;
    logic [RP_W-1:0] rp_q, rp_n, rp_target;
    logic            first_q, first_n;
    logic            level_n, press_n, release_n;

    assign sync_lvl     = sync_q[SYNC_STAGES-1];
    assign rp_target    = first_q ? RP_PERIOD : RP_FIRST;
    assign press_next_c = press_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= '0;
            state_q       <= IDLE;
            db_q          <= '0;
            rp_q          <= '0;
            first_q       <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], pressed};
            state_q       <= state_n;
            db_q          <= db_n;
            rp_q          <= rp_n;
            first_q       <= first_n;
            level         <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
        end
    end

    // Counters are compared against target-1 so the accepting sample is itself counted.
    always_comb begin
        state_n   = state_q;
        db_n      = db_q;
        rp_n      = rp_q;
        first_n   = first_q;
        level_n   = level;
        press_n   = 1'b0;
        release_n = 1'b0;

        case (state_q)
            IDLE: begin
                db_n = '0;
                if (sync_lvl) begin
                    if (DB_ONE) begin
                        state_n = HELD;
                        level_n = 1'b1;
                        press_n = 1'b1;
                        rp_n    = '0;
                        first_n = 1'b0;
                    end else begin
                        state_n = PRESS_DB;
                        db_n    = DB_W'(1);
                    end
                end
            end
            PRESS_DB: begin
                if (!sync_lvl) begin
                    state_n = IDLE;
                    db_n    = '0;
                end else if (db_q >= DB_LAST) begin
                    state_n = HELD;
                    db_n    = '0;
                    level_n = 1'b1;
                    press_n = 1'b1;
                    rp_n    = '0;
                    first_n = 1'b0;
                end else begin
                    db_n = db_q + DB_W'(1);
                end
            end
            HELD: begin
                if (!sync_lvl) begin
                    if (DB_ONE) begin
                        state_n   = IDLE;
                        level_n   = 1'b0;
                        release_n = 1'b1;
                    end else begin
                        state_n = REL_DB;
                        db_n    = DB_W'(1);
                    end
                end else if (rp_q >= rp_target) begin
                    rp_n    = '0;
                    first_n = 1'b1;
                    press_n = repeat_en;
                end else begin
                    rp_n = rp_q + RP_W'(1);
                end
            end
            REL_DB: begin
                // Repeat timer keeps running but holds just short of a tick.
                if (rp_q < rp_target) begin
                    rp_n = rp_q + RP_W'(1);
                end
                if (sync_lvl) begin
                    state_n = HELD;
                    db_n    = '0;
                end else if (db_q >= DB_LAST) begin
                    state_n   = IDLE;
                    db_n      = '0;
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else begin
                    db_n = db_q + DB_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: polarity fix, per-channel conditioning, any_press OR.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            any_press
);

    logic [N_CH-1:0] pressed_raw;
    logic [N_CH-1:0] press_next_c;

    assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .pressed      (pressed_raw[i]),
            .repeat_en    (repeat_en[i]),
            .level        (level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .press_next_c (press_next_c[i])
        );
    end

    // Registered from the channels' next-pulse terms so it lines up with press_pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next_c;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DB=4, DELAY=8, PERIOD=3, active-low).
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] repeat_en;
    logic [3:0] level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       any_press;

    int n_checks = 0;
    int n_errors = 0;

    button_conditioner #(
        .N_CH           (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (3),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .repeat_en    (repeat_en),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .any_press    (any_press)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] lv,
                              input logic [3:0] pp, input logic [3:0] rp);
        check({tag, "_level"}, level, lv);
        check({tag, "_press"}, press_pulse, pp);
        check({tag, "_release"}, release_pulse, rp);
        check({tag, "_any"}, {3'b000, any_press}, {3'b000, |pp});
    endtask

    initial begin
        reset     = 1'b1;
        btn_in    = 4'hF;
        repeat_en = 4'h0;
        #1;
        check_outs("reset", 4'h0, 4'h0, 4'h0);
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check_outs("idle", 4'h0, 4'h0, 4'h0);
        end

        // 1: single press on ch0, then release
        btn_in[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            check_outs("t1_press", (c >= 5) ? 4'h1 : 4'h0, (c == 5) ? 4'h1 : 4'h0, 4'h0);
        end
        btn_in[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check_outs("t1_rel", (c >= 5) ? 4'h0 : 4'h1, 4'h0, (c == 5) ? 4'h1 : 4'h0);
        end
        repeat (4) step();

        // 2: three-cycle glitch on ch1 is rejected
        btn_in[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_outs("t2_glitch", 4'h0, 4'h0, 4'h0);
        end
        btn_in[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check_outs("t2_after", 4'h0, 4'h0, 4'h0);
        end

        // 3: auto-repeat on ch2, pulses at press +0,+8,+11,+14,+17,+20
        repeat_en = 4'b0100;
        btn_in[2] = 1'b0;
        for (int c = 0; c <= 25; c++) begin
            step();
            check_outs("t3_hold", (c >= 5) ? 4'h4 : 4'h0,
                       (c == 5 || c == 13 || c == 16 || c == 19 || c == 22 || c == 25) ? 4'h4 : 4'h0,
                       4'h0);
        end
        btn_in[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check_outs("t3_rel", (c >= 5) ? 4'h0 : 4'h4, 4'h0, (c == 5) ? 4'h4 : 4'h0);
        end
        repeat_en = 4'h0;
        repeat (4) step();

        // 4: repeat_en dropped after first repeat suppresses later ticks
        repeat_en = 4'b0100;
        btn_in[2] = 1'b0;
        for (int c = 0; c <= 25; c++) begin
            step();
            check_outs("t4_hold", (c >= 5) ? 4'h4 : 4'h0,
                       (c == 5 || c == 13) ? 4'h4 : 4'h0, 4'h0);
            if (c == 13) repeat_en = 4'h0;
        end
        btn_in[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check_outs("t4_rel", (c >= 5) ? 4'h0 : 4'h4, 4'h0, (c == 5) ? 4'h4 : 4'h0);
        end
        repeat (4) step();

        // 5: simultaneous press on ch0 and ch3
        btn_in = 4'b0110;
        for (int c = 0; c < 8; c++) begin
            step();
            check_outs("t5_press", (c >= 5) ? 4'h9 : 4'h0, (c == 5) ? 4'h9 : 4'h0, 4'h0);
        end
        btn_in = 4'hF;
        for (int c = 0; c < 8; c++) begin
            step();
            check_outs("t5_rel", (c >= 5) ? 4'h0 : 4'h9, 4'h0, (c == 5) ? 4'h9 : 4'h0);
        end
        repeat (4) step();

        // 6: reset while ch1 held, then fresh debounce with key still down
        btn_in[1] = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            check_outs("t6_press", (c >= 5) ? 4'h2 : 4'h0, (c == 5) ? 4'h2 : 4'h0, 4'h0);
        end
        reset = 1'b1;
        #1;
        check_outs("t6_rst_async", 4'h0, 4'h0, 4'h0);
        for (int c = 0; c < 2; c++) begin
            step();
            check_outs("t6_rst_hold", 4'h0, 4'h0, 4'h0);
        end
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            check_outs("t6_restart", (c >= 6) ? 4'h2 : 4'h0, (c == 6) ? 4'h2 : 4'h0, 4'h0);
        end
        btn_in[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check_outs("t6_rel", (c >= 5) ? 4'h0 : 4'h2, 4'h0, (c == 5) ? 4'h2 : 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
